// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect, instruction-memory and decode signals of the fetch stage.
// FETCH_MISALIGN_TRAP_EN adds if_misalign.
interface fetch_stage_if #(parameter int XLEN = 32);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            if_misalign;
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4, if_misalign
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4, if_misalign
    );
`else
    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4
    );
    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_inst, if_pc_plus4
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, keeps one imem request in flight and hands {pc, inst} to decode.
// FETCH_MISALIGN_TRAP_EN presents misaligned redirect targets as a trap instead of masking them.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h13);
    state_t          state;
    logic [XLEN-1:0] pc, opc, inst, tgt;
    logic            req, vld, mis, discard, gnt, bad, busy;
    assign gnt  = req && bus.imem_gnt;
    // a request is still in flight after this edge: granted now, or waiting with no response yet
    assign busy = (state == REQ && gnt) || (state == WAIT && !bus.imem_rvalid);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt             = bus.redirect_pc;
    assign bad             = |bus.redirect_pc[1:0];
    assign bus.if_misalign = mis;
`else
    assign tgt = bus.redirect_pc & ~XLEN'(3);
    assign bad = 1'b0;
`endif
    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.if_valid    = vld;
    assign bus.if_pc       = opc;
    assign bus.if_inst     = inst;
    assign bus.if_pc_plus4 = opc + XLEN'(4);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= REQ;
            pc      <= RESET_PC;
            opc     <= RESET_PC;
            inst    <= NOP;
            req     <= 1'b0;
            vld     <= 1'b0;
            mis     <= 1'b0;
            discard <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc      <= tgt;
            vld     <= bad;
            mis     <= bad;
            req     <= !bad && !busy;
            discard <= (discard || busy) && !(state == WAIT && bus.imem_rvalid);
            state   <= bad ? HOLD : busy ? WAIT : REQ;
            if (bad) begin
                opc  <= tgt;
                inst <= NOP;
            end
        end else begin
            case (state)
                REQ: begin
                    req <= !gnt;
                    if (gnt) state <= WAIT;
                end
                WAIT: if (bus.imem_rvalid) begin
                    discard <= 1'b0;
                    if (discard) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end else begin
                        opc   <= pc;
                        inst  <= bus.imem_rdata;
                        vld   <= 1'b1;
                        pc    <= pc + XLEN'(4);
                        state <= HOLD;
                    end
                end
                HOLD: if (bus.if_ready) begin
                    vld <= 1'b0;
                    // a trapped fetch stays parked until the next redirect
                    if (!mis) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random memory/decode/redirect stimulus; a scoreboard of expected PCs checks what decode sees.
module tb_fetch_stage;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] K      = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP    = 32'h13;
    logic clk = 1'b0, rst_n = 1'b1;
    int total = 0, bad = 0, acc = 0;
    int gnt_pct = 100, lat_max = 1;
    bit mem_busy = 1'b0;
    logic [31:0] exp_q[$];
    fetch_stage_if #(.XLEN(32)) bus();
    fetch_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [31:0] tgt_of(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t;
`else
        return t & ~32'd3;
`endif
    endfunction

    // Memory: grants randomly, answers each grant once after 1..lat_max cycles with addr^K.
    initial begin
        bit g;
        int lat;
        logic [31:0] a, raddr;
        lat = 0; raddr = 0;
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            g = bus.imem_req && bus.imem_gnt;
            a = bus.imem_addr;
            if (!rst_n) begin
                mem_busy = 1'b0; lat = 0; g = 1'b0;
            end else if (g) chk("single_outstanding", 32'(mem_busy), 32'd0);
            @(posedge clk); #1;
            if (bus.imem_rvalid) begin
                bus.imem_rvalid = 1'b0;
                mem_busy = 1'b0;
            end
            if (g) begin
                mem_busy = 1'b1;
                lat = $urandom_range(1, lat_max);
                raddr = a;
            end
            if (mem_busy && lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata = raddr ^ K;
                end
            end
            bus.imem_gnt = ($urandom_range(1, 100) <= gnt_pct);
        end
    end

    // Monitor: whatever decode sees must be the PC at the head of the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e, ei;
        if (rst_n && !bus.redirect_valid && bus.if_valid) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else begin
                e = exp_q[0];
                ei = (e[1:0] != 2'b00) ? NOP : e ^ K;
                chk("if_pc", bus.if_pc, e);
                chk("if_inst", bus.if_inst, ei);
                chk("if_pc_plus4", bus.if_pc_plus4, e + 32'd4);
                chk("no_req_while_valid", 32'(bus.imem_req), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
                chk("if_misalign", 32'(bus.if_misalign), 32'(e[1:0] != 2'b00));
`endif
                if (bus.if_ready) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(e + 32'd4);
                    acc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = t;
        exp_q.delete();
        exp_q.push_back(tgt_of(t));
        step();
        bus.redirect_valid = 1'b0;
    endtask

    function automatic bit cond(input int k);
        return k == 0 ? mem_busy && !bus.imem_rvalid : k == 1 ? bus.if_valid :
               k == 2 ? bus.imem_rvalid : bus.imem_req;
    endfunction

    task automatic wait_cond(input int k);
        int n = 0;
        while (!cond(k) && n < 200) begin
            step();
            n++;
        end
        chk($sformatf("wait_cond%0d_timeout", k), 32'(cond(k)), 32'd1);
    endtask

    task automatic wait_acc(input int n);
        int s = acc + n, c = 0;
        while (acc < s && c < 500) begin
            step();
            c++;
        end
        chk("progress_timeout", 32'(acc >= s), 32'd1);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_if_pc", bus.if_pc, RST_PC);
        chk("rst_if_inst", bus.if_inst, NOP);
        chk("rst_if_pc_plus4", bus.if_pc_plus4, RST_PC + 32'd4);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        repeat (2) step();
        #1 rst_n = 1'b1;
        step();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RST_PC);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b1;
        do_reset();
        wait_acc(4);
        // decode backpressure
        bus.if_ready = 1'b0;
        wait_cond(1);
        repeat (5) step();
        bus.if_ready = 1'b1;
        wait_acc(2);
        // redirect while a fetch is in flight
        lat_max = 3;
        wait_cond(0);
        redirect(32'hAABB_CCDC);
        wait_cond(3);
        chk("redirect_addr", bus.imem_addr, 32'hAABB_CCDC);
        wait_acc(2);
        // redirect coincident with a response
        wait_cond(2);
        redirect(32'h0000_0200);
        wait_acc(2);
        // redirect coincident with decode accepting
        wait_cond(1);
        redirect(32'h0000_0400);
        wait_acc(2);
        // wrap-around
        redirect(32'hFFFF_FFFC);
        wait_acc(2);
        // random traffic
        gnt_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            bus.if_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom;
                redirect(r & ~32'd3);
            end else step();
        end
        bus.if_ready = 1'b1;
        wait_acc(1);
        // async reset mid-WAIT, then with an instruction held
        wait_cond(0);
        do_reset();
        wait_acc(3);
        bus.if_ready = 1'b0;
        wait_cond(1);
        do_reset();
        bus.if_ready = 1'b1;
        wait_acc(3);
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.if_ready = 1'b0;
        wait_cond(1);
        redirect(32'h0000_0102);
        chk("trap_valid", 32'(bus.if_valid), 32'd1);
        chk("trap_misalign", 32'(bus.if_misalign), 32'd1);
        chk("trap_pc", bus.if_pc, 32'h102);
        chk("trap_inst", bus.if_inst, NOP);
        chk("trap_no_req", 32'(bus.imem_req), 32'd0);
        bus.if_ready = 1'b1;
        repeat (4) begin
            step();
            chk("trap_stall_valid", 32'(bus.if_valid), 32'd0);
            chk("trap_stall_req", 32'(bus.imem_req), 32'd0);
        end
        redirect(32'h0000_0300);
        wait_acc(2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that owns the architectural PC register and consumes the next-PC produced by the branch sequencer.
- Issues one instruction-memory request at a time and returns fetched instruction plus PC to decode via valid/ready.
- Produces PC+4, which becomes the sequencer's not-taken target.
- Handles redirects arriving while a fetch is in flight by discarding the stale response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- redirect_valid  in  1  one-cycle pulse; sequencer resolved a taken branch/jump.
- redirect_pc  in  XLEN  target from sequencer npc.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  XLEN  request address (current PC).
- imem_gnt  in  1  memory accepts request when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; at most one per granted request, ≥1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts when if_valid && if_ready.
- if_pc  out  XLEN  PC of presented instruction.
- if_inst  out  XLEN  presented instruction.
- if_pc_plus4  out  XLEN  if_pc + 4, feeds sequencer notbranch.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC; state=REQ; imem_req=0; if_valid=0; if_pc=RESET_PC; if_inst=32'h0000_0013 (NOP); discard=0.
- imem_req goes high in the first cycle after reset release.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT.
  - WAIT: await imem_rvalid.
    - If discard=0: capture {pc, imem_rdata} into the output register, set if_valid=1, pc<=pc+4, go to HOLD.
    - If discard=1: drop the data, clear discard, go to REQ (pc already holds the redirect target).
  - HOLD: if_valid=1.
    - On if_ready: if_valid<=0, go to REQ. Same-cycle re-request is not required; this gives 1 bubble.
- Steady-state latency: grant-to-if_valid = response latency; at most one outstanding request ever.
- Redirect (redirect_valid=1) has priority over everything in the same cycle:
  - pc<=redirect_pc; if_valid<=0 (presented instruction squashed even if if_ready is also high).
  - In REQ with the grant in the same cycle: the request was issued to the old pc; set discard=1 and go to WAIT.
  - In REQ without a grant: stay in REQ. imem_addr changes next cycle, which is legal because the request was not granted.
  - In WAIT with no rvalid that cycle: discard<=1.
  - In WAIT with rvalid the same cycle: drop the response, discard stays 0, go to REQ.
  - In HOLD: go to REQ.
- Back-to-back redirects: the last one wins; discard stays set until the single outstanding response returns.
- if_pc_plus4 = if_pc + 4, combinational, modulo 2^XLEN (wraps 32'hFFFF_FFFC → 32'h0000_0000). pc+4 wraps identically.
- imem_req stays stable until granted, except when a redirect changes the address.
- Reset asserted mid-transaction aborts all state immediately. A memory response arriving after reset release with no outstanding request is ignored: rvalid is only sampled in WAIT.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output if_misalign (1 bit, reset 0).
  - A redirect_pc with bits [1:0] != 0 issues no memory request. Instead the next cycle presents if_valid=1, if_misalign=1, if_pc=redirect_pc, if_inst=NOP (HOLD state).
  - The block then stalls in HOLD until the next redirect. if_ready clears if_valid but does not resume fetch.
- Undefined:
  - Port absent; redirect_pc[1:0] are forced to 0 before being loaded into pc.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: RESET_PC=0, gnt always 1, rvalid 1 cycle after grant, rdata=addr^32'hA5A5A5A5, if_ready=1.
  - Required: if_pc sequence 0,4,8,C; if_inst matches; if_pc_plus4=if_pc+4.
- Decode backpressure:
  - Stimulus: if_ready=0 for 5 cycles with if_valid=1.
  - Required: if_pc/if_inst held stable, imem_req=0 throughout; fetch resumes after if_ready=1.
- Redirect in WAIT:
  - Stimulus: fetch at 32'h10 outstanding, redirect_valid with redirect_pc=32'hAABBCCDC, response arrives 2 cycles later.
  - Required: response dropped (no if_valid); next imem_addr=32'hAABBCCDC; presented if_pc=32'hAABBCCDC.
- Redirect coincident with rvalid and with if_ready in HOLD:
  - Required: nothing presented for the old PC; next request is to redirect_pc.
- Wrap-around:
  - Stimulus: redirect_pc=32'hFFFF_FFFC.
  - Required: if_pc_plus4=0; next fetch address 32'h0000_0000.
- Async reset mid-WAIT:
  - Stimulus: drop rst_n between clock edges.
  - Required: if_valid=0 and imem_req=0 immediately; after release, first imem_addr=RESET_PC. With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102 → if_misalign=1, if_pc=32'h102, no imem_req.
